// File: rtl/max_pool_strobe_rx.sv
`default_nettype none
// ============================================================================
// Module   : max_pool_strobe_rx
// Brief    : Signed max-pooling of strobe-qualified pixels with a valid/ready
//            result register, overflow flag and strobe period monitor.
// Revision : 1.0 - initial release
// ============================================================================
module max_pool_strobe_rx #(
    parameter int DATA_W  = 8,
    parameter int POOL    = 4,
    parameter int DIVISOR = 6
) (
    input  logic                          clock_in,
    input  logic                          reset_n,
    input  logic                          strobe_in,
    input  logic                          clear_in,
    input  logic [DATA_W-1:0]             pixel_in,
    output logic [DATA_W-1:0]             max_out,
    output logic                          max_valid,
    input  logic                          max_ready,
    output logic                          overflow,
    output logic                          period_err,
    output logic [$clog2(POOL+1)-1:0]     window_cnt
);

    localparam int                CNT_W     = $clog2(POOL + 1);
    localparam logic [CNT_W-1:0]  C_LAST    = CNT_W'(POOL - 1);
    localparam logic [CNT_W-1:0]  C_ONE     = CNT_W'(1);
    localparam logic [7:0]        C_PER_MAX = 8'd255;
    localparam logic [7:0]        C_DIVISOR = 8'(DIVISOR);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    state_t                    state_q;
    logic                      strobe_q;
    logic signed [DATA_W-1:0]  acc_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [DATA_W-1:0]         max_q;
    logic                      valid_q;
    logic                      overflow_q;
    logic [7:0]                period_q;
    logic                      seen_q;
    logic                      period_err_q;

    logic                      w_rise;
    logic                      w_done;
    logic signed [DATA_W-1:0]  w_pix;
    logic signed [DATA_W-1:0]  acc_d;

    assign w_rise = strobe_in & ~strobe_q;
    assign w_pix  = $signed(pixel_in);
    // IDLE starts a fresh window; strict '>' leaves acc untouched on ties.
    assign acc_d  = ((state_q == S_IDLE) || (w_pix > acc_q)) ? w_pix : acc_q;
    assign w_done = w_rise && (state_q == S_ACC) && (cnt_q == C_LAST);

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= strobe_in;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (clear_in) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (w_rise) begin
            acc_q <= acc_d;
            case (state_q)
                S_IDLE: begin
                    cnt_q   <= C_ONE;
                    state_q <= S_ACC;
                end
                S_ACC: begin
                    if (w_done) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + C_ONE;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Result register: a completion may replace a result only as it is accepted.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            max_q      <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else if (clear_in) begin
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else if (w_done) begin
            if (!valid_q || max_ready) begin
                max_q   <= acc_d;
                valid_q <= 1'b1;
            end else begin
                overflow_q <= 1'b1;
            end
        end else if (valid_q && max_ready) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            period_q     <= '0;
            seen_q       <= 1'b0;
            period_err_q <= 1'b0;
        end else if (clear_in) begin
            period_q     <= '0;
            seen_q       <= 1'b0;
            period_err_q <= 1'b0;
        end else if (w_rise) begin
            period_q <= 8'd1;
            seen_q   <= 1'b1;
            if (seen_q && (period_q != C_DIVISOR)) begin
                period_err_q <= 1'b1;
            end
        end else if (period_q != C_PER_MAX) begin
            period_q <= period_q + 8'd1;
        end
    end

    assign max_out    = max_q;
    assign max_valid  = valid_q;
    assign overflow   = overflow_q;
    assign period_err = period_err_q;
    assign window_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_max_pool_strobe_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_max_pool_strobe_rx
// Brief    : Self-checking bench: vector table plus result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_max_pool_strobe_rx;

    localparam int DATA_W  = 8;
    localparam int POOL    = 4;
    localparam int DIVISOR = 6;
    localparam int CNT_W   = $clog2(POOL + 1);
    localparam int N_VEC   = 6;

    logic              clock_in = 1'b0;
    logic              reset_n;
    logic              strobe_in;
    logic              clear_in;
    logic [DATA_W-1:0] pixel_in;
    logic [DATA_W-1:0] max_out;
    logic              max_valid;
    logic              max_ready;
    logic              overflow;
    logic              period_err;
    logic [CNT_W-1:0]  window_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [DATA_W-1:0] sb_q[$];

    typedef struct packed {
        logic [POOL-1:0][DATA_W-1:0] px;
        logic [DATA_W-1:0]           exp_max;
    } vec_t;

    vec_t vecs[N_VEC];

    max_pool_strobe_rx #(
        .DATA_W (DATA_W),
        .POOL   (POOL),
        .DIVISOR(DIVISOR)
    ) dut (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .strobe_in (strobe_in),
        .clear_in  (clear_in),
        .pixel_in  (pixel_in),
        .max_out   (max_out),
        .max_valid (max_valid),
        .max_ready (max_ready),
        .overflow  (overflow),
        .period_err(period_err),
        .window_cnt(window_cnt)
    );

    always #5 clock_in = ~clock_in;

    function automatic vec_t mk(input int a, input int b, input int c, input int d, input int e);
        vec_t v;
        v.px[0]   = a[DATA_W-1:0];
        v.px[1]   = b[DATA_W-1:0];
        v.px[2]   = c[DATA_W-1:0];
        v.px[3]   = d[DATA_W-1:0];
        v.exp_max = e[DATA_W-1:0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Mid-cycle: score any handshake about to happen; then advance past the edge.
    task automatic tick();
        @(negedge clock_in);
        if (max_valid && max_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL scoreboard: unexpected result 0x%0h", max_out);
            end else begin
                chk("sb_max_out", 32'(max_out), 32'(sb_q.pop_front()));
            end
        end
        @(posedge clock_in);
        #1;
    endtask

    // One strobe pulse carrying p, then low so the next rise is 'period' cycles later.
    task automatic send_sample(input int p, input int period);
        strobe_in = 1'b1;
        pixel_in  = p[DATA_W-1:0];
        tick();
        strobe_in = 1'b0;
        pixel_in  = 8'h7F;
        repeat (period - 1) tick();
    endtask

    task automatic do_clear();
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        strobe_in = 1'b0;
        clear_in  = 1'b0;
        max_ready = 1'b1;
        pixel_in  = '0;

        vecs[0] = mk(3, -7, 12, 5, 12);
        vecs[1] = mk(-128, -1, -50, -3, -1);
        vecs[2] = mk(0, 0, 0, 0, 0);
        vecs[3] = mk(127, -128, 5, 127, 127);
        vecs[4] = mk(-5, -5, -5, -5, -5);
        vecs[5] = mk(-100, -20, 49, 50, 50);

        repeat (2) tick();
        chk("rst_max_out",    32'(max_out), 0);
        chk("rst_max_valid",  32'(max_valid), 0);
        chk("rst_window_cnt", 32'(window_cnt), 0);
        chk("rst_overflow",   32'(overflow), 0);
        chk("rst_period_err", 32'(period_err), 0);
        reset_n = 1'b1;
        tick();

        // Table-driven windows at the nominal strobe period, consumer always ready.
        for (int v = 0; v < N_VEC; v++) begin
            sb_q.push_back(vecs[v].exp_max);
            for (int j = 0; j < POOL; j++) begin
                strobe_in = 1'b1;
                pixel_in  = vecs[v].px[j];
                tick();
                if (j == POOL - 1) begin
                    chk("vec_valid_after_rise", 32'(max_valid), 1);
                    chk("vec_max_out", 32'(max_out), 32'(vecs[v].exp_max));
                    chk("vec_cnt_wrap", 32'(window_cnt), 0);
                end else begin
                    chk("vec_cnt", 32'(window_cnt), j + 1);
                end
                strobe_in = 1'b0;
                pixel_in  = 8'h7F;
                tick();
                if (j == POOL - 1) chk("vec_valid_one_cycle", 32'(max_valid), 0);
                repeat (DIVISOR - 2) tick();
            end
            chk("vec_period_err", 32'(period_err), 0);
            chk("vec_overflow", 32'(overflow), 0);
        end

        // Clear beats a simultaneous rise; a held strobe gives one sample.
        strobe_in = 1'b1;
        pixel_in  = 8'd99;
        clear_in  = 1'b1;
        tick();
        clear_in = 1'b0;
        chk("clr_rise_discarded", 32'(window_cnt), 0);
        chk("clr_keeps_max_out", 32'(max_out), 50);
        repeat (3) tick();
        chk("clr_held_no_rise", 32'(window_cnt), 0);
        strobe_in = 1'b0;
        tick();
        strobe_in = 1'b1;
        pixel_in  = 8'd33;
        repeat (10) tick();
        chk("held_one_sample", 32'(window_cnt), 1);
        strobe_in = 1'b0;
        do_clear();
        chk("clr_cnt", 32'(window_cnt), 0);

        // Period monitor: spacing 6, 6, 5.
        sb_q.push_back(8'd4);
        send_sample(1, 6);
        send_sample(2, 6);
        chk("per_ok_after_2", 32'(period_err), 0);
        send_sample(3, 5);
        chk("per_ok_before_short", 32'(period_err), 0);
        strobe_in = 1'b1;
        pixel_in  = 8'd4;
        tick();
        chk("per_err_on_short", 32'(period_err), 1);
        chk("per_window_max", 32'(max_out), 4);
        strobe_in = 1'b0;
        pixel_in  = 8'h7F;
        repeat (5) tick();
        send_sample(5, 6);
        send_sample(6, 6);
        chk("per_err_sticky", 32'(period_err), 1);
        do_clear();
        chk("per_err_cleared", 32'(period_err), 0);

        // Back-pressure: second window dropped while first unaccepted.
        max_ready = 1'b0;
        sb_q.push_back(8'd9);
        send_sample(1, 6); send_sample(9, 6); send_sample(-3, 6); send_sample(2, 6);
        send_sample(20, 6); send_sample(5, 6); send_sample(6, 6); send_sample(7, 6);
        chk("ovf_max_kept", 32'(max_out), 9);
        chk("ovf_valid_held", 32'(max_valid), 1);
        chk("ovf_flag", 32'(overflow), 1);
        do_clear();
        void'(sb_q.pop_front());
        chk("ovf_clr_max_kept", 32'(max_out), 9);
        chk("ovf_clr_valid", 32'(max_valid), 0);
        chk("ovf_clr_flag", 32'(overflow), 0);

        // Completion coinciding with acceptance replaces the result.
        sb_q.push_back(8'd9);
        send_sample(1, 6); send_sample(9, 6); send_sample(-3, 6); send_sample(2, 6);
        sb_q.push_back(8'd20);
        send_sample(4, 6); send_sample(20, 6); send_sample(-9, 6);
        max_ready = 1'b1;
        strobe_in = 1'b1;
        pixel_in  = 8'd11;
        tick();
        chk("same_cycle_valid", 32'(max_valid), 1);
        chk("same_cycle_max", 32'(max_out), 20);
        chk("same_cycle_ovf", 32'(overflow), 0);
        strobe_in = 1'b0;
        pixel_in  = 8'h7F;
        repeat (5) tick();
        chk("same_cycle_drained", 32'(max_valid), 0);

        // Reset mid-window.
        send_sample(-10, 6);
        send_sample(30, 6);
        chk("pre_rst_cnt", 32'(window_cnt), 2);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_max_out", 32'(max_out), 0);
        chk("mid_rst_valid", 32'(max_valid), 0);
        chk("mid_rst_cnt", 32'(window_cnt), 0);
        chk("mid_rst_flags", 32'({overflow, period_err}), 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        sb_q.push_back(8'hEC);
        send_sample(-60, 6);
        chk("post_rst_cnt", 32'(window_cnt), 1);
        send_sample(-20, 6); send_sample(-40, 6); send_sample(-30, 6);
        chk("post_rst_max", 32'(max_out), 32'hEC);
        chk("post_rst_period_err", 32'(period_err), 0);
        chk("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/max_pool_strobe_rx.md
MAX_POOL_STROBE_RX -- requirements
Module: max_pool_strobe_rx

Interface
REQ-001 Parameter DATA_W, default 8, pixel width in bits; pixels are two's-complement signed.
REQ-002 Parameter POOL, default 4, samples per pooling window; legal range 2..16.
REQ-003 Parameter DIVISOR, default 6, expected clock_in cycles between strobe rising edges.
REQ-004 clock_in  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 strobe_in  input  1  divided sample strobe from the clock divider, synchronous to clock_in.
REQ-007 clear_in  input  1  synchronous soft clear.
REQ-008 pixel_in  input  DATA_W  pixel sampled on each strobe rising edge.
REQ-009 max_out  output  DATA_W  pooled maximum of the last complete window.
REQ-010 max_valid  output  1  max_out holds an unaccepted result.
REQ-011 max_ready  input  1  consumer accepts max_out when high with max_valid.
REQ-012 overflow  output  1  sticky; a completed window was dropped.
REQ-013 period_err  output  1  sticky; strobe period differed from DIVISOR.
REQ-014 window_cnt  output  clog2(POOL+1)  samples accumulated in the current window.

Function
REQ-015 The block SHALL register strobe_in into strobe_q each cycle; rise = strobe_in AND NOT strobe_q.
REQ-016 Samples SHALL be taken only on rise cycles; pixel_in is sampled in the same cycle; a held-high strobe SHALL yield exactly one sample.
REQ-017 The window FSM SHALL have two states: IDLE (window_cnt=0) and ACC (1..POOL-1 samples).
REQ-018 IDLE + rise: acc <= pixel_in, window_cnt <= 1, next state ACC.
REQ-019 ACC + rise: acc <= signed max(acc, pixel_in), window_cnt incremented; on the POOL-th sample the window completes, window_cnt <= 0 and state <= IDLE in the same cycle.
REQ-020 Comparison SHALL be signed over the full DATA_W with no truncation; on equal values acc is unchanged.
REQ-021 A completed window SHALL load max_out and assert max_valid on the clock edge after the POOL-th rise (latency 1 cycle).
REQ-022 max_valid SHALL remain high and max_out stable until a cycle with max_valid=1 and max_ready=1; max_valid falls on the following edge unless a new result loads on that edge.
REQ-023 Completion with max_valid=1 and max_ready=1 in the same cycle SHALL load the new result; max_valid stays 1 and no overflow is raised.
REQ-024 Completion with max_valid=1 and max_ready=0 SHALL drop the new result, keep max_out, and set overflow.
REQ-025 A period counter SHALL count clock_in cycles since the last rise, saturating at 255, and reset to 1 on each rise.
REQ-026 On every rise except the first after reset or clear, a counter value different from DIVISOR SHALL set period_err.
REQ-027 clear_in=1 SHALL return the FSM to IDLE, zero acc, window_cnt, max_valid, overflow, period_err and the period counter, and re-arm the first-rise exemption; clear_in takes priority over a simultaneous rise, which is discarded.
REQ-028 max_out SHALL NOT be modified by clear_in.

Reset
REQ-029 reset_n=0 SHALL immediately force state IDLE, strobe_q=0, acc=0, max_out=0, max_valid=0, window_cnt=0, overflow=0, period_err=0 and period counter=0, independent of clock_in.
REQ-030 Reset asserted mid-window SHALL discard the partial window; the first rise after release starts a new window and is exempt from the period check.

Verification
REQ-031 Strobe period 6, pixels 3,-7,12,5, max_ready=1 -> max_out=12, max_valid high exactly 1 cycle, one cycle after the 4th rise; period_err=0.
REQ-032 Pixels -128,-1,-50,-3 -> max_out=-1 (0xFF), proving signed comparison.
REQ-033 max_ready=0 across two complete windows (maxima 9, then 20) -> max_out stays 9, overflow=1 after the 2nd completion; completion in the same cycle as max_ready=1 -> max_out=20, max_valid stays 1, overflow=0.
REQ-034 Strobe held high for 10 cycles -> exactly one sample, window_cnt=1.
REQ-035 Rises at spacing 6,6,5 -> period_err=1 on the third of those rises and remains set until clear_in or reset.
REQ-036 reset_n pulsed low after 2 samples -> all outputs 0 during reset; a following 4-sample window yields the correct maximum with period_err=0.
